// File: rtl/gray_window_engine.sv
// -----------------------------------------------------------------------------
// gray_window_engine
//   Converts a WIN x WIN RGB window to bypass / gray / inverted gray / binary
//   threshold. LANES shared converters are time-multiplexed over
//   BEATS = ceil(N/LANES) beats. Sits between the line-buffer window generator
//   and the kernel/VGA output stage, with valid/ready on both sides.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high
//   mode_i     00 bypass, 01 gray, 10 inverted gray, 11 threshold
//   thr_i      threshold used in mode 11
//   in_valid   window on win_i is valid
//   in_ready   engine can accept a window (IDLE)
//   win_i      pixel k = r*WIN+c at [k*PIX_W +: PIX_W], {R,G,B}, R in MSBs
//   out_valid  win_o holds a complete result (DONE)
//   out_ready  downstream accepts the result
//   win_o      result window, same packing as win_i
//   busy_o     high in CONV or DONE
// -----------------------------------------------------------------------------
module gray_window_engine #(
  parameter  int WIN     = 3,
  parameter  int COLOR_W = 4,
  parameter  int LANES   = 3,
  localparam int N       = WIN * WIN,
  localparam int PIX_W   = 3 * COLOR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode_i,
  input  logic [COLOR_W-1:0]   thr_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*PIX_W-1:0]   win_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*PIX_W-1:0]   win_o,
  output logic                 busy_o
);

  localparam int BEATS  = (N + LANES - 1) / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int S_W    = COLOR_W + 8;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [N*PIX_W-1:0]   win_q, win_d;       // captured input window
  logic [1:0]           mode_q, mode_d;     // captured mode
  logic [COLOR_W-1:0]   thr_q, thr_d;       // captured threshold
  logic [N*PIX_W-1:0]   win_o_q, win_o_d;   // result window
  logic [PIX_W-1:0]     lane_res [LANES];

  // One converter: weighted luma with +128 rounding, then mode-dependent output.
  function automatic logic [PIX_W-1:0] convert(input logic [PIX_W-1:0]   px,
                                                input logic [1:0]         mode,
                                                input logic [COLOR_W-1:0] thr);
    logic [S_W-1:0]     r, g_ch, b, s;
    logic [COLOR_W-1:0] g;
    r    = S_W'(px[PIX_W-1 -: COLOR_W]);
    g_ch = S_W'(px[2*COLOR_W-1 -: COLOR_W]);
    b    = S_W'(px[COLOR_W-1:0]);
    s    = r * S_W'(77) + g_ch * S_W'(150) + b * S_W'(29) + S_W'(128);
    g    = s[S_W-1:8];
    case (mode)
      2'b00:   convert = px;
      2'b01:   convert = {g, g, g};
      2'b10:   convert = {~g, ~g, ~g};
      default: convert = (g >= thr) ? '1 : '0;
    endcase
  endfunction

  // Lane l serves pixel beat*LANES+l; lanes past the last pixel idle at zero.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_res[l] = '0;
      if (int'(beat_q) * LANES + l < N)
        lane_res[l] = convert(win_q[(int'(beat_q) * LANES + l) * PIX_W +: PIX_W],
                              mode_q, thr_q);
    end
  end

  // State register. Every register, including the captured window and the
  // result window, is cleared so a reset mid-window leaves nothing behind.
  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      win_q   <= '0;
      mode_q  <= '0;
      thr_q   <= '0;
      win_o_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      win_q   <= win_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      win_o_q <= win_o_d;
    end
  end

  // Next-state logic for control and datapath.
  // NOTE: every signal gets a hold default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    win_d   = win_q;
    mode_d  = mode_q;
    thr_d   = thr_q;
    win_o_d = win_o_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          win_d   = win_i;
          mode_d  = mode_i;
          thr_d   = thr_i;
          beat_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        // Only pixels of the current beat are rewritten; the rest keep the
        // previous result until their beat comes round.
        for (int k = 0; k < N; k++) begin
          if (k / LANES == int'(beat_q))
            win_o_d[k*PIX_W +: PIX_W] = lane_res[k % LANES];
        end
        if (beat_q == BEAT_W'(BEATS - 1)) state_d = DONE;
        else                              beat_d  = beat_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy_o    = (state_q != IDLE);
  end

  assign win_o = win_o_q;

endmodule
